// File: rtl/input_event_capture.sv
// Debounced switch/button capture with a show-ahead event FIFO pulled through valid/ready.
// Optional feature: define AUTOREPEAT_EN to queue periodic repeat events for held buttons.
module input_event_capture #(
    parameter int TICK_DIV   = 100000,
    parameter int DEB_N      = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int REP_DELAY  = 500,
    parameter int REP_PERIOD = 100
) (
    input  logic        IN_CLK,
    input  logic        IN_RST_N,
    input  logic [15:0] IN_SWITCH,
    input  logic [4:0]  IN_BTN,
    output logic [15:0] OUT_SWITCH,
    output logic [4:0]  OUT_BTN_LEVEL,
    output logic [4:0]  OUT_BTN_PRESS,
    output logic        OUT_EVT_VALID,
    output logic [5:0]  OUT_EVT_DATA,
    input  logic        IN_EVT_READY,
    output logic        OUT_OVF
);
    // Bit slots 0-4 are buttons, 5-20 are switches; lower slot drains first.
    localparam int NB = 21;
    localparam int TW = $clog2(TICK_DIV);
    localparam int SW = $clog2(DEB_N + 1);
    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic {ST_SEED, ST_RUN} state_e;

    state_e                   state_q, state_d;
    logic [TW-1:0]            tick_cnt_q, tick_cnt_d;
    logic [SW-1:0]            seed_cnt_q, seed_cnt_d;
    logic [NB-1:0]            sync1_q, sync1_d, sync2_q, sync2_d;
    logic [NB-1:0][DEB_N-1:0] hist_q, hist_d;
    logic [NB-1:0]            stable_q, stable_d;
    logic [NB-1:0]            pending_q, pending_d;
    logic [4:0]               pend_rep_q, pend_rep_d;
    logic [4:0]               press_q, press_d;
    logic                     ovf_q, ovf_d;
    logic [AW-1:0]            wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]              count_q, count_d;
    logic [5:0]               mem_q [FIFO_DEPTH];

    logic          tick, push, pop, full, wr_en;
    logic [4:0]    sel_idx;
    logic [5:0]    push_data;
    logic [NB-1:0] flip;
    logic [4:0]    rep_fire;

`ifdef AUTOREPEAT_EN
    localparam int REP_MAX = (REP_DELAY > REP_PERIOD) ? REP_DELAY : REP_PERIOD;
    localparam int RW      = $clog2(REP_MAX + 1);
    logic [4:0][RW-1:0] rep_cnt_q, rep_cnt_d;
`endif

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        tick       = (tick_cnt_q == TW'(TICK_DIV - 1));
        tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
        sync1_d    = {IN_SWITCH, IN_BTN};
        sync2_d    = sync1_q;
        hist_d     = hist_q;
        stable_d   = stable_q;
        state_d    = state_q;
        seed_cnt_d = seed_cnt_q;
        flip       = '0;

        if (tick) begin
            for (int i = 0; i < NB; i++) begin
                hist_d[i] = {hist_q[i][DEB_N-2:0], sync2_q[i]};
                if (state_q == ST_SEED) begin
                    stable_d[i] = sync2_q[i];
                end else if ((&hist_d[i] && !stable_q[i]) || (~|hist_d[i] && stable_q[i])) begin
                    flip[i]     = 1'b1;
                    stable_d[i] = ~stable_q[i];
                end
            end
            if (state_q == ST_SEED) begin
                seed_cnt_d = seed_cnt_q + 1'b1;
                if (seed_cnt_q == SW'(DEB_N - 1)) state_d = ST_RUN;
            end
        end

        press_d = flip[4:0] & stable_d[4:0];

`ifdef AUTOREPEAT_EN
        // Counter holds ticks until the next repeat; zero means not armed.
        rep_cnt_d = rep_cnt_q;
        rep_fire  = '0;
        if (tick && state_q == ST_RUN) begin
            for (int i = 0; i < 5; i++) begin
                if (flip[i]) begin
                    rep_cnt_d[i] = stable_d[i] ? RW'(REP_DELAY) : '0;
                end else if (stable_q[i] && rep_cnt_q[i] != '0) begin
                    if (rep_cnt_q[i] == RW'(1)) begin
                        rep_fire[i]  = 1'b1;
                        rep_cnt_d[i] = RW'(REP_PERIOD);
                    end else begin
                        rep_cnt_d[i] = rep_cnt_q[i] - 1'b1;
                    end
                end
            end
        end
`else
        rep_fire = '0;
`endif

        pending_d  = pending_q;
        pend_rep_d = pend_rep_q;
        push_data  = '0;
        sel_idx    = '0;
        push       = |pending_q;
        for (int i = NB - 1; i >= 0; i--) begin
            if (pending_q[i]) sel_idx = 5'(i);
        end
        if (push) begin
            pending_d[sel_idx] = 1'b0;
            if (sel_idx < 5'd5) begin
                pend_rep_d[sel_idx[2:0]] = 1'b0;
                if (pend_rep_q[sel_idx[2:0]])
                    push_data = {2'b11, 1'b0, sel_idx[2:0]};
                else
                    push_data = {(stable_q[sel_idx] ? 2'b00 : 2'b01), 1'b0, sel_idx[2:0]};
            end else begin
                push_data = {2'b10, 4'(sel_idx - 5'd5)};
            end
        end
        pending_d  = pending_d | flip | {16'b0, rep_fire};
        pend_rep_d = pend_rep_d | rep_fire;

        // A pop frees the slot in the same cycle, so push+pop while full is lossless.
        pop      = (count_q != '0) && IN_EVT_READY;
        full     = (count_q == (AW + 1)'(FIFO_DEPTH));
        wr_en    = push && (!full || pop);
        ovf_d    = ovf_q | (push && full && !pop);
        wr_ptr_d = wr_en ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        case ({wr_en, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge IN_CLK or negedge IN_RST_N) begin
        if (!IN_RST_N) begin
            state_q    <= ST_SEED;
            tick_cnt_q <= '0;
            seed_cnt_q <= '0;
            sync1_q    <= '0;
            sync2_q    <= '0;
            hist_q     <= '0;
            stable_q   <= '0;
            pending_q  <= '0;
            pend_rep_q <= '0;
            press_q    <= '0;
            ovf_q      <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
`ifdef AUTOREPEAT_EN
            rep_cnt_q  <= '0;
`endif
        end else begin
            state_q    <= state_d;
            tick_cnt_q <= tick_cnt_d;
            seed_cnt_q <= seed_cnt_d;
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            hist_q     <= hist_d;
            stable_q   <= stable_d;
            pending_q  <= pending_d;
            pend_rep_q <= pend_rep_d;
            press_q    <= press_d;
            ovf_q      <= ovf_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
`ifdef AUTOREPEAT_EN
            rep_cnt_q  <= rep_cnt_d;
`endif
        end
    end

    // NOTE: storage is not reset; the output mux hides stale entries while empty.
    always_ff @(posedge IN_CLK) begin
        if (wr_en) mem_q[wr_ptr_q] <= push_data;
    end

    assign OUT_SWITCH    = stable_q[20:5];
    assign OUT_BTN_LEVEL = stable_q[4:0];
    assign OUT_BTN_PRESS = press_q;
    assign OUT_OVF       = ovf_q;
    assign OUT_EVT_VALID = (count_q != '0);
    assign OUT_EVT_DATA  = OUT_EVT_VALID ? mem_q[rd_ptr_q] : '0;

endmodule
